// File: rtl/demux_pkg.sv
// Shared constants, slot record type and helpers for the stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).

// One buffered beat: valid flag plus payload of width W.
`define DEMUX_SLOT_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package demux_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int MAX_CH     = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel.
// Latency: a loaded beat is visible on out_valid/out_data the cycle after load.
// Backpressure: holds valid/data steady until out_ready; a load in the draining cycle replaces the beat.

module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef `DEMUX_SLOT_T(DATA_WIDTH) slot_t;

  slot_t slot_q;

  // Load has priority over drain so back-to-back beats stream at full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (load) begin
      slot_q.valid <= 1'b1;
      slot_q.data  <= in_data;
    end else if (out_ready) begin
      slot_q.valid <= 1'b0;
    end
  end

  assign out_valid = slot_q.valid;
  assign out_data  = slot_q.data;

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1:NUM_CH stream demux with broadcast, invalid-select drop and drop counter.
// Latency: one cycle from input acceptance to out_valid on the target channel(s).
// Backpressure: in_ready follows the target slot(s) being free or draining; broadcast waits for all.

module demux_stream_n
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [SEL_WIDTH-1:0]         in_sel,
  input  logic                         in_bcast,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         sel_err,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  logic [NUM_CH-1:0] free_vec;
  logic [NUM_CH-1:0] tgt_vec;
  logic [NUM_CH-1:0] load_vec;
  logic              sel_ok;
  logic              in_acc;
  logic              drop_vld;

  // Decode the target set; an out-of-range select matches no channel.
  always_comb begin
    sel_ok   = int'(in_sel) < NUM_CH;
    free_vec = ~out_valid | out_ready;
    tgt_vec  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      tgt_vec[k] = in_bcast | (in_sel == SEL_WIDTH'(k));
    end
  end

  // Broadcast needs every slot so it never lands partially; bad selects are always taken.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &free_vec;
    end else if (sel_ok) begin
      in_ready = |(tgt_vec & free_vec);
    end
  end

  assign in_acc   = in_valid & in_ready;
  assign load_vec = in_acc ? tgt_vec : '0;
  assign drop_vld = in_acc & ~in_bcast & ~sel_ok;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_vec[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Report each dropped beat as a one-cycle pulse and a saturating tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= drop_vld;
      if (drop_vld) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule
